insn_fetch_resp: RTL

INSN_FETCH_RESP -- requirements
Module: insn_fetch_resp

---
 rtl/insn_fetch_resp_if.sv | 46 ++++
 rtl/insn_fetch_resp.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_resp_if.sv
// ---------------------------------------------------------------------------
// insn_fetch_resp_if
// Bundles the core-side fetch handshake and the memory-side read port of
// insn_fetch_resp.
//   slave  : the fetch responder (consumes fetch requests, issues memory reads)
//   master : the environment (core + memory) driving the responder
// Core side  : fetch_req, fetch_pc, fetch_hart_id, fetch_flush, inv ->
//              insn, insn_valid, fetch_stall, fetch_err
// Memory side: mem_rd_req, mem_addr -> mem_rd_data, mem_ack
// ---------------------------------------------------------------------------
interface insn_fetch_resp_if #(
  parameter int HART_NUM = 4
);
  localparam int HART_W = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;

  // Core side
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic [HART_W-1:0] fetch_hart_id;
  logic              fetch_flush;
  logic              inv;
  logic [31:0]       insn;
  logic              insn_valid;
  logic              fetch_stall;
  logic              fetch_err;

  // Memory side
  logic              mem_rd_req;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_rd_data;
  logic              mem_ack;

  modport slave (
    input  fetch_req, fetch_pc, fetch_hart_id, fetch_flush, inv,
    input  mem_rd_data, mem_ack,
    output insn, insn_valid, fetch_stall, fetch_err,
    output mem_rd_req, mem_addr
  );

  modport master (
    output fetch_req, fetch_pc, fetch_hart_id, fetch_flush, inv,
    output mem_rd_data, mem_ack,
    input  insn, insn_valid, fetch_stall, fetch_err,
    input  mem_rd_req, mem_addr
  );
endinterface

// File: rtl/insn_fetch_resp.sv
// ---------------------------------------------------------------------------
// insn_fetch_resp
// Per-hart single-entry instruction buffer in front of a simple memory read
// port. A request whose hart entry holds the same pc is answered in the same
// cycle; otherwise the core is stalled while the line is read from memory,
// after which the retried fetch hits.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous active-high reset
//   bus    : insn_fetch_resp_if.slave (core fetch handshake + memory read)
//
// States
//   IDLE  : serve hits, launch misses, reject misaligned pcs
//   BUSY  : memory read in flight, bounded by TIMEOUT cycles
//   DRAIN : fetch was flushed; wait for the pending ack and drop its data
//   ERR   : timeout or misaligned fetch; left only through fetch_flush
// ---------------------------------------------------------------------------
`ifndef OP_NOP
`define OP_NOP 32'h0000_0013
`endif

module insn_fetch_resp #(
  parameter int HART_NUM = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  insn_fetch_resp_if.slave   bus
);

  localparam int HART_W = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DRAIN,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [HART_W-1:0] hart_q, hart_d;

  logic [HART_NUM-1:0] valid_q;
  logic [31:0]         tag_q  [HART_NUM];
  logic [31:0]         data_q [HART_NUM];

  logic        fill;
  logic        hit;
  logic        insn_valid_c;
  logic        stall_c;
  logic        err_c;
  logic        rd_req_c;

  assign hit = valid_q[bus.fetch_hart_id] && (tag_q[bus.fetch_hart_id] == bus.fetch_pc);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    hart_d       = hart_q;
    fill         = 1'b0;
    insn_valid_c = 1'b0;
    stall_c      = 1'b0;
    err_c        = 1'b0;
    rd_req_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.fetch_req) begin
          if (bus.fetch_pc[1:0] != 2'b00) begin
            // Misaligned: report through ERR without touching memory.
            stall_c = 1'b1;
            state_d = S_ERR;
          end else if (hit) begin
            insn_valid_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            pc_d    = bus.fetch_pc;
            hart_d  = bus.fetch_hart_id;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        rd_req_c = 1'b1;
        stall_c  = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // An ack always completes the fill, even alongside a flush.
        if (bus.mem_ack) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end else if (bus.fetch_flush) begin
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end
      end

      S_DRAIN: begin
        // Keep the read open until memory answers; the data is dropped.
        rd_req_c = 1'b1;
        stall_c  = 1'b1;
        if (bus.mem_ack) state_d = S_IDLE;
      end

      S_ERR: begin
        err_c   = 1'b1;
        stall_c = 1'b1;
        if (bus.fetch_flush) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if the core keeps
  // presenting a request.
  assign bus.insn_valid  = insn_valid_c && !reset;
  assign bus.fetch_stall = stall_c      && !reset;
  assign bus.fetch_err   = err_c        && !reset;
  assign bus.mem_rd_req  = rd_req_c     && !reset;
  assign bus.mem_addr    = pc_q;
  assign bus.insn        = bus.insn_valid ? data_q[bus.fetch_hart_id] : `OP_NOP;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      hart_q  <= '0;
      valid_q <= '0;
      // NOTE: the buffer is small enough to reset in full; tags and data
      // come out of reset as zero rather than unknown.
      for (int i = 0; i < HART_NUM; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      hart_q  <= hart_d;
      if (fill) begin
        tag_q[hart_q]  <= pc_q;
        data_q[hart_q] <= bus.mem_rd_data;
      end
      // Invalidate takes priority over a fill landing in the same cycle.
      if (bus.inv) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[hart_q] <= 1'b1;
      end
    end
  end

endmodule
